// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one outstanding imem request at a time,
// and holds the returned word in a one-entry buffer until IF/ID takes it (NOP bubble when empty).
module if_fetch_unit #(
  parameter int                       WORD_BITWIDTH = 32,
  parameter logic [WORD_BITWIDTH-1:0] RESET_PC      = '0,
  parameter logic [WORD_BITWIDTH-1:0] NOP_INSN      = WORD_BITWIDTH'(32'h0000_0013)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     hz_write,
  input  logic                     redirect,
  input  logic [WORD_BITWIDTH-1:0] redirect_pc,
  output logic                     imem_req,
  output logic [WORD_BITWIDTH-1:0] imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [WORD_BITWIDTH-1:0] imem_rdata,
  output logic [WORD_BITWIDTH-1:0] pc,
  output logic [WORD_BITWIDTH-1:0] instruction
);

  localparam logic [WORD_BITWIDTH-1:0] PC_STEP = WORD_BITWIDTH'(4);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t                     state;
  logic [WORD_BITWIDTH-1:0]   fetch_pc;
  logic [WORD_BITWIDTH-1:0]   req_pc;
  logic                       buf_valid;
  logic [WORD_BITWIDTH-1:0]   buf_pc;
  logic [WORD_BITWIDTH-1:0]   buf_insn;
  logic                       kill;
  logic                       consume;

  assign consume = buf_valid & ~hz_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      req_pc    <= '0;
      buf_valid <= 1'b0;
      buf_pc    <= '0;
      buf_insn  <= '0;
      kill      <= 1'b0;
    end else begin
      if (consume) buf_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (!redirect && (!buf_valid || consume)) begin
            state  <= REQ;
            req_pc <= fetch_pc;
          end
        end
        REQ: begin
          if (imem_gnt) begin
            state <= WAIT;
            if (!kill && !redirect) fetch_pc <= fetch_pc + PC_STEP;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            state <= IDLE;
            if (!kill && !redirect) begin
              buf_valid <= 1'b1;
              buf_pc    <= req_pc;
              buf_insn  <= imem_rdata;
            end else begin
              kill <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // A redirect never withdraws the pending request; it only marks its response as stale.
      if (redirect) begin
        fetch_pc  <= redirect_pc;
        buf_valid <= 1'b0;
        if (state == REQ || (state == WAIT && !imem_rvalid)) kill <= 1'b1;
      end
    end
  end

  assign imem_req    = (state == REQ);
  assign imem_addr   = req_pc;
  assign pc          = buf_valid ? buf_pc : '0;
  assign instruction = buf_valid ? buf_insn : NOP_INSN;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: one instance at RESET_PC=0, one at RESET_PC=FFFF_FFFC for wrap/reset.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst, hz_write, redirect, imem_gnt, imem_rvalid, imem_req;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, pc, instruction;

  logic        rst2, gnt2, rvalid2, req2;
  logic [31:0] rdata2, addr2, pc2, insn2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .hz_write(hz_write), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .pc(pc), .instruction(instruction)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst2), .hz_write(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
    .imem_req(req2), .imem_addr(addr2), .imem_gnt(gnt2), .imem_rvalid(rvalid2),
    .imem_rdata(rdata2), .pc(pc2), .instruction(insn2)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered in a REQ cycle for `a`; returns in the cycle the word for `a` is offered.
  // The rvalid cycle also checks the outputs are a bubble, i.e. the buffer is empty on response.
  task automatic fetch_one(input logic [31:0] a);
    chk("req_hi", {31'b0, imem_req}, 32'd1);
    chk("req_addr", imem_addr, a);
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0;
    chk("wait_req_lo", {31'b0, imem_req}, 32'd0);
    chk("buf_empty_on_rsp", instruction, NOP);
    imem_rvalid = 1'b1;
    imem_rdata  = a ^ KEY;
    cyc();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    chk("offer_pc", pc, a);
    chk("offer_insn", instruction, a ^ KEY);
  endtask

  initial begin
    rst = 1'b1; hz_write = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    rst2 = 1'b1; gnt2 = 1'b0; rvalid2 = 1'b0; rdata2 = '0;

    // Reset
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_insn", instruction, NOP);
    chk("rst_pc", pc, 32'd0);
    cyc();

    // Steady fetch with a bubble between words
    fetch_one(32'd0);
    cyc();
    chk("bubble_insn", instruction, NOP);
    chk("bubble_pc", pc, 32'd0);
    fetch_one(32'd4);
    cyc();
    fetch_one(32'd8);

    // Stall holding pc=8
    hz_write = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_pc", pc, 32'd8);
      chk("stall_insn", instruction, 32'd8 ^ KEY);
      chk("stall_noreq", {31'b0, imem_req}, 32'd0);
    end
    hz_write = 1'b0;
    cyc();
    fetch_one(32'd12);

    // Redirect during WAIT, rvalid two cycles later
    cyc();
    chk("r1_req", imem_addr, 32'd16);
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h100;
    cyc();
    redirect = 1'b0;
    cyc();
    imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
    cyc();
    imem_rvalid = 1'b0;
    chk("r1_drop_insn", instruction, NOP);
    chk("r1_drop_req", {31'b0, imem_req}, 32'd0);
    cyc();
    fetch_one(32'h100);

    // Redirect coincident with grant
    cyc();
    chk("r2_req", imem_addr, 32'h104);
    imem_gnt = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    cyc();
    imem_gnt = 1'b0; redirect = 1'b0;
    chk("r2_wait", {31'b0, imem_req}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222;
    cyc();
    imem_rvalid = 1'b0;
    chk("r2_drop_insn", instruction, NOP);
    cyc();
    fetch_one(32'h200);

    // Redirect coincident with rvalid
    cyc();
    chk("r3_req", imem_addr, 32'h204);
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h3333_3333;
    redirect = 1'b1; redirect_pc = 32'h300;
    cyc();
    imem_rvalid = 1'b0; redirect = 1'b0;
    chk("r3_drop_insn", instruction, NOP);
    chk("r3_drop_pc", pc, 32'd0);
    cyc();
    fetch_one(32'h300);

    // Redirect while buffered under stall
    hz_write = 1'b1;
    cyc();
    chk("r4_held", pc, 32'h300);
    redirect = 1'b1; redirect_pc = 32'h40;
    cyc();
    redirect = 1'b0;
    chk("r4_clear_insn", instruction, NOP);
    chk("r4_clear_pc", pc, 32'd0);
    chk("r4_noreq", {31'b0, imem_req}, 32'd0);
    cyc();
    hz_write = 1'b0;
    fetch_one(32'h40);

    // Wrap and reset during WAIT on the second instance
    rst2 = 1'b0;
    chk("w_rst_req", {31'b0, req2}, 32'd0);
    cyc();
    chk("w_req0", addr2, 32'hFFFF_FFFC);
    gnt2 = 1'b1;
    cyc();
    gnt2 = 1'b0;
    rvalid2 = 1'b1; rdata2 = 32'hCAFE_0001;
    cyc();
    rvalid2 = 1'b0;
    chk("w_pc0", pc2, 32'hFFFF_FFFC);
    chk("w_insn0", insn2, 32'hCAFE_0001);
    cyc();
    chk("w_req1_hi", {31'b0, req2}, 32'd1);
    chk("w_wrap_addr", addr2, 32'd0);
    gnt2 = 1'b1;
    cyc();
    gnt2 = 1'b0;
    rst2 = 1'b1;
    cyc();
    rst2 = 1'b0;
    chk("w_mid_rst_req", {31'b0, req2}, 32'd0);
    chk("w_mid_rst_insn", insn2, NOP);
    rvalid2 = 1'b1; rdata2 = 32'hBAD0_BAD0;
    cyc();
    rvalid2 = 1'b0;
    chk("w_stale_ignored", insn2, NOP);
    chk("w_restart_req", {31'b0, req2}, 32'd1);
    chk("w_restart_addr", addr2, 32'hFFFF_FFFC);
    gnt2 = 1'b1;
    cyc();
    gnt2 = 1'b0;
    rvalid2 = 1'b1; rdata2 = 32'hCAFE_0002;
    cyc();
    rvalid2 = 1'b0;
    chk("w_restart_pc", pc2, 32'hFFFF_FFFC);
    chk("w_restart_insn", insn2, 32'hCAFE_0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
